// File: rtl/spi_lcd_stream.sv
// SPI mode-0 LCD streamer: panel power/wake sequence, init ROM playback, then RAMWR
// frames assembled from BUS_WIDTH-bit pixel words pulled with a ready/valid handshake.
module spi_lcd_stream #(
    parameter int unsigned CLK_DIV      = 1,
    parameter int unsigned STARTUP_WAIT = 2700000,
    parameter int unsigned RESET_WAIT   = 5400000,
    parameter int unsigned BUS_WIDTH    = 256,
    parameter int unsigned FRAME_BYTES  = 64800,
    parameter int unsigned INIT_LEN     = 16,
    parameter logic [9*INIT_LEN-1:0] INIT_ROM = {
        9'h1EF, 9'h100, 9'h100, 9'h100, 9'h02B, 9'h186, 9'h100, 9'h100,
        9'h100, 9'h02A, 9'h029, 9'h021, 9'h105, 9'h03A, 9'h100, 9'h036},
    parameter int unsigned AUTO_START   = 1
) (
    input  logic                 t_clk,
    input  logic                 t_rst,
    output logic                 spi_mclk,
    output logic                 spi_mosi,
    output logic                 spi_cs,
    output logic                 spi_rs,
    output logic                 spi_reset,
    input  logic [BUS_WIDTH-1:0] buffer,
    input  logic                 bufferDA,
    output logic                 bufferRtR,
    input  logic                 frame_start,
    output logic                 frame_done,
    output logic                 busy
);
    localparam int unsigned NB    = BUS_WIDTH / 8;
    localparam int unsigned IDX_W = (NB > 1) ? $clog2(NB) : 1;

    typedef enum logic [3:0] {
        StPower, StWake, StWakeWait, StInitLoad, StSend,
        StInitNext, StIdle, StRamwr, StFill, StStream
    } state_e;
    typedef enum logic [1:0] {RetWake, RetInit, RetRamwr} ret_e;

    state_e               state_q, state_d;
    ret_e                 ret_q, ret_d;
    logic [31:0]          cnt_q, cnt_d;
    logic [15:0]          div_q, div_d;
    logic [2:0]           bit_q, bit_d;
    logic                 phase_q, phase_d;
    logic [7:0]           shift_q, shift_d;
    logic [5:0]           init_idx_q, init_idx_d;
    logic [23:0]          byte_cnt_q, byte_cnt_d;
    logic [BUS_WIDTH-1:0] word_q, word_d;
    logic [IDX_W-1:0]     word_idx_q, word_idx_d;
    logic                 mclk_q, mclk_d, mosi_q, mosi_d, cs_q, cs_d, rs_q, rs_d;
    logic                 lcd_rst_q, lcd_rst_d, done_q, done_d;
    logic                 start_byte, byte_end;
    logic [7:0]           start_val;

    always_ff @(posedge t_clk or posedge t_rst) begin
        if (t_rst) begin
            state_q    <= StPower;
            ret_q      <= RetWake;
            cnt_q      <= '0;
            div_q      <= '0;
            bit_q      <= '0;
            phase_q    <= 1'b0;
            shift_q    <= '0;
            init_idx_q <= '0;
            byte_cnt_q <= '0;
            word_q     <= '0;
            word_idx_q <= '0;
            mclk_q     <= 1'b0;
            mosi_q     <= 1'b1;
            cs_q       <= 1'b1;
            rs_q       <= 1'b1;
            lcd_rst_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ret_q      <= ret_d;
            cnt_q      <= cnt_d;
            div_q      <= div_d;
            bit_q      <= bit_d;
            phase_q    <= phase_d;
            shift_q    <= shift_d;
            init_idx_q <= init_idx_d;
            byte_cnt_q <= byte_cnt_d;
            word_q     <= word_d;
            word_idx_q <= word_idx_d;
            mclk_q     <= mclk_d;
            mosi_q     <= mosi_d;
            cs_q       <= cs_d;
            rs_q       <= rs_d;
            lcd_rst_q  <= lcd_rst_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ret_d      = ret_q;
        cnt_d      = cnt_q;
        div_d      = div_q;
        bit_d      = bit_q;
        phase_d    = phase_q;
        shift_d    = shift_q;
        init_idx_d = init_idx_q;
        byte_cnt_d = byte_cnt_q;
        word_d     = word_q;
        word_idx_d = word_idx_q;
        mclk_d     = mclk_q;
        mosi_d     = mosi_q;
        cs_d       = cs_q;
        rs_d       = rs_q;
        lcd_rst_d  = lcd_rst_q;
        done_d     = 1'b0;
        start_byte = 1'b0;
        start_val  = 8'h00;
        byte_end   = 1'b0;

        // Bit engine: low half then high half per bit; mosi moves only with the falling edge.
        if (state_q == StSend || state_q == StStream) begin
            if (div_q == 16'(CLK_DIV - 1)) begin
                div_d = '0;
                if (!phase_q) begin
                    phase_d = 1'b1;
                    mclk_d  = 1'b1;
                end else if (bit_q == 3'd7) begin
                    byte_end = 1'b1;
                    phase_d  = 1'b0;
                    mclk_d   = 1'b0;
                end else begin
                    phase_d = 1'b0;
                    mclk_d  = 1'b0;
                    bit_d   = bit_q + 3'd1;
                    shift_d = {shift_q[6:0], 1'b0};
                    mosi_d  = shift_q[6];
                end
            end else begin
                div_d = div_q + 16'd1;
            end
        end

        case (state_q)
            StPower: begin
                cnt_d = cnt_q + 32'd1;
                if (cnt_q == STARTUP_WAIT - 1) lcd_rst_d = 1'b1;
                if (cnt_q == 2 * STARTUP_WAIT - 1) begin
                    cnt_d   = '0;
                    rs_d    = 1'b0;
                    state_d = StWake;
                end
            end
            StWake: begin
                start_byte = 1'b1;
                start_val  = 8'h11;
                ret_d      = RetWake;
                state_d    = StSend;
            end
            StWakeWait: begin
                cnt_d = cnt_q + 32'd1;
                if (cnt_q == RESET_WAIT - 1) begin
                    cnt_d      = '0;
                    init_idx_d = '0;
                    rs_d       = INIT_ROM[8];
                    state_d    = StInitLoad;
                end
            end
            StInitLoad: begin
                start_byte = 1'b1;
                start_val  = INIT_ROM[9*init_idx_q +: 8];
                ret_d      = RetInit;
                state_d    = StSend;
            end
            StSend: begin
                if (byte_end) begin
                    cs_d = 1'b1;
                    case (ret_q)
                        RetWake: begin
                            cnt_d   = '0;
                            state_d = StWakeWait;
                        end
                        RetInit: state_d = StInitNext;
                        default: begin
                            rs_d    = 1'b1;
                            state_d = StFill;
                        end
                    endcase
                end
            end
            StInitNext: begin
                // rs is set here, a cycle ahead of the cs fall in StInitLoad.
                if (init_idx_q == 6'(INIT_LEN - 1)) begin
                    state_d = StIdle;
                end else begin
                    init_idx_d = init_idx_q + 6'd1;
                    rs_d       = INIT_ROM[9*(init_idx_q + 6'd1) + 8];
                    state_d    = StInitLoad;
                end
            end
            StIdle: begin
                if (AUTO_START != 0 || frame_start) begin
                    rs_d       = 1'b0;
                    byte_cnt_d = '0;
                    state_d    = StRamwr;
                end
            end
            StRamwr: begin
                start_byte = 1'b1;
                start_val  = 8'h2C;
                ret_d      = RetRamwr;
                state_d    = StSend;
            end
            StFill: begin
                cs_d = 1'b0;
                if (bufferDA) begin
                    word_d     = buffer;
                    word_idx_d = '0;
                    start_byte = 1'b1;
                    start_val  = buffer[7:0];
                    state_d    = StStream;
                end
            end
            StStream: begin
                if (byte_end) begin
                    byte_cnt_d = byte_cnt_q + 24'd1;
                    if (byte_cnt_q == 24'(FRAME_BYTES - 1)) begin
                        cs_d       = 1'b1;
                        done_d     = 1'b1;
                        byte_cnt_d = '0;
                        state_d    = StIdle;
                    end else if (word_idx_q == IDX_W'(NB - 1)) begin
                        state_d = StFill;
                    end else begin
                        word_idx_d = word_idx_q + IDX_W'(1);
                        start_byte = 1'b1;
                        start_val  = word_q[8*(word_idx_q + IDX_W'(1)) +: 8];
                    end
                end
            end
            default: state_d = StPower;
        endcase

        if (start_byte) begin
            shift_d = start_val;
            mosi_d  = start_val[7];
            cs_d    = 1'b0;
            mclk_d  = 1'b0;
            div_d   = '0;
            bit_d   = '0;
            phase_d = 1'b0;
        end
    end

    assign spi_mclk   = mclk_q;
    assign spi_mosi   = mosi_q;
    assign spi_cs     = cs_q;
    assign spi_rs     = rs_q;
    assign spi_reset  = lcd_rst_q;
    assign frame_done = done_q;
    assign bufferRtR  = (state_q == StFill);
    assign busy       = (state_q != StIdle);
endmodule

// File: tb/tb_spi_lcd_stream.sv
// Bench for spi_lcd_stream: a byte-level SPI monitor pops expected {rs,byte} records from a
// scoreboard queue filled as stimulus is driven; a second instance checks CLK_DIV=3 timing.
module tb_spi_lcd_stream;
    typedef struct {
        logic [15:0] word;
        int unsigned dly;
        logic [8:0]  exp_b0;
        logic [8:0]  exp_b1;
        bit          b1_sent;
    } vec_t;

    logic        t_clk = 1'b0;
    logic        t_rst = 1'b1;
    logic        spi_mclk, spi_mosi, spi_cs, spi_rs, spi_reset;
    logic [15:0] buffer = 16'h0;
    logic        bufferDA = 1'b0, frame_start = 1'b0;
    logic        bufferRtR, frame_done, busy;

    logic        m3_mclk, m3_mosi, m3_cs, m3_rs, m3_reset, m3_rtr, m3_done, m3_busy;
    logic [15:0] m3_buffer = 16'h0;
    logic        m3_da = 1'b0, m3_start = 1'b0;

    logic [8:0]  exp_q[$];
    int          n_vec = 0, n_err = 0;
    int          done_cnt = 0, cs_rises = 0;
    bit          done3 = 1'b0;
    vec_t        vecs[9];

    initial forever #5 t_clk = ~t_clk;

    spi_lcd_stream #(
        .CLK_DIV(1), .STARTUP_WAIT(4), .RESET_WAIT(8), .BUS_WIDTH(16), .FRAME_BYTES(5),
        .INIT_LEN(2), .INIT_ROM({9'h105, 9'h03A}), .AUTO_START(0)
    ) u_dut (
        .t_clk(t_clk), .t_rst(t_rst), .spi_mclk(spi_mclk), .spi_mosi(spi_mosi),
        .spi_cs(spi_cs), .spi_rs(spi_rs), .spi_reset(spi_reset), .buffer(buffer),
        .bufferDA(bufferDA), .bufferRtR(bufferRtR), .frame_start(frame_start),
        .frame_done(frame_done), .busy(busy)
    );

    spi_lcd_stream #(
        .CLK_DIV(3), .STARTUP_WAIT(4), .RESET_WAIT(8), .BUS_WIDTH(16), .FRAME_BYTES(5),
        .INIT_LEN(2), .INIT_ROM({9'h105, 9'h03A}), .AUTO_START(0)
    ) u_dut3 (
        .t_clk(t_clk), .t_rst(t_rst), .spi_mclk(m3_mclk), .spi_mosi(m3_mosi),
        .spi_cs(m3_cs), .spi_rs(m3_rs), .spi_reset(m3_reset), .buffer(m3_buffer),
        .bufferDA(m3_da), .bufferRtR(m3_rtr), .frame_start(m3_start),
        .frame_done(m3_done), .busy(m3_busy)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // Byte monitor: shifts mosi on each mclk rise while cs is low, sampled mid-cycle.
    initial begin : mon
        logic [7:0] sh;
        logic [8:0] e;
        int         bits;
        logic       mprev, cprev, dprev;
        bits = 0; sh = 8'h0; mprev = 1'b0; cprev = 1'b1; dprev = 1'b0;
        forever begin
            @(negedge t_clk);
            if (t_rst || spi_cs) begin
                bits = 0;
            end else if (spi_mclk && !mprev) begin
                sh = {sh[6:0], spi_mosi};
                bits++;
                if (bits == 8) begin
                    bits = 0;
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL spi_byte: got %h, nothing expected", {spi_rs, sh});
                    end else begin
                        e = exp_q.pop_front();
                        check("spi_byte", {23'd0, spi_rs, sh}, {23'd0, e});
                    end
                end
            end
            if (!t_rst && spi_cs && !cprev) cs_rises++;
            if (frame_done) begin
                done_cnt++;
                check("done_width", dprev, 0);
            end
            mprev = spi_mclk; cprev = spi_cs; dprev = frame_done;
        end
    end

    // CLK_DIV=3 instance: wake byte must be 48 cycles of 3-cycle half periods.
    initial begin : chk3
        int n, len, run;
        logic pm, pmo, ok, stop;
        logic [7:0] sh;
        @(negedge t_rst);
        n = 0;
        while (m3_cs && n < 200) begin @(posedge t_clk); #1; n++; end
        check("div3_cs_fall", m3_cs, 0);
        len = 1; run = 1; ok = 1'b1; stop = 1'b0; sh = 8'h0;
        pm = m3_mclk; pmo = m3_mosi;
        while (!stop) begin
            @(posedge t_clk); #1;
            if (m3_cs || len >= 400) begin
                stop = 1'b1;
            end else begin
                len++;
                if (m3_mclk != pm) begin
                    if (run != 3) ok = 1'b0;
                    run = 1;
                    if (m3_mclk) sh = {sh[6:0], m3_mosi};
                end else begin
                    run++;
                end
                if (m3_mosi != pmo && m3_mclk) ok = 1'b0;
                pm = m3_mclk; pmo = m3_mosi;
            end
        end
        if (run != 3) ok = 1'b0;
        check("div3_byte_len", len, 48);
        check("div3_half_periods", ok, 1);
        check("div3_byte", sh, 8'h11);
        done3 = 1'b1;
    end

    task automatic power_up();
        int n;
        exp_q.delete();
        exp_q.push_back(9'h011);
        exp_q.push_back(9'h03A);
        exp_q.push_back(9'h105);
        @(negedge t_clk);
        t_rst = 1'b0;
        n = 0;
        while (n == 0 || (spi_reset === 1'b0 && n < 100)) begin @(posedge t_clk); #1; n++; end
        check("reset_low_cycles", n, 4);
        n = 0;
        while (spi_cs && n < 100) begin @(posedge t_clk); #1; n++; end
        check("wake_cs_fall", spi_cs, 0);
        n = 0;
        while (!spi_cs && n < 100) begin n++; @(posedge t_clk); #1; end
        check("wake_byte_cycles", n, 16);
        // 8-cycle wake wait plus the cycle that loads the first init entry.
        n = 0;
        while (spi_cs && n < 100) begin n++; @(posedge t_clk); #1; end
        check("wake_wait_gap", n, 9);
        n = 0;
        while (busy && n < 300) begin @(posedge t_clk); #1; n++; end
        check("init_busy_fall", busy, 0);
        repeat (2) @(posedge t_clk);
        #1;
        check("init_bytes_left", exp_q.size(), 0);
    endtask

    task automatic supply(input vec_t v, input bit poke);
        int n;
        logic ok;
        if (poke) begin
            frame_start = 1'b1;
            @(posedge t_clk); #1;
            frame_start = 1'b0;
        end
        n = 0;
        while (bufferRtR !== 1'b1 && n < 500) begin @(posedge t_clk); #1; n++; end
        check("rtr_rise", bufferRtR, 1);
        ok = 1'b1;
        for (int k = 0; k < int'(v.dly); k++) begin
            @(posedge t_clk); #1;
            if (spi_mclk !== 1'b0 || spi_cs !== 1'b0 || bufferRtR !== 1'b1) ok = 1'b0;
        end
        if (v.dly >= 10) check("fill_stretch", ok, 1);
        buffer = v.word;
        bufferDA = 1'b1;
        exp_q.push_back(v.exp_b0);
        if (v.b1_sent) exp_q.push_back(v.exp_b1);
        @(posedge t_clk); #1;
        check("rtr_drop", bufferRtR, 0);
        // DA left high with junk while rtr is low; the captured word must survive.
        buffer = 16'hDEAD;
        repeat (2) begin @(posedge t_clk); #1; end
        bufferDA = 1'b0;
        buffer = 16'($urandom);
    endtask

    task automatic run_frame(input int f, input bit poke);
        int d0, r0, n;
        d0 = done_cnt;
        r0 = cs_rises;
        exp_q.push_back(9'h02C);
        frame_start = 1'b1;
        @(posedge t_clk); #1;
        frame_start = 1'b0;
        for (int i = 0; i < 3; i++) supply(vecs[3*f+i], poke && i == 1);
        n = 0;
        while (busy && n < 300) begin @(posedge t_clk); #1; n++; end
        check("frame_end_busy", busy, 0);
        repeat (2) @(posedge t_clk);
        #1;
        check("frame_done_count", done_cnt - d0, 1);
        check("frame_cs_rises", cs_rises - r0, 2);
        check("frame_bytes_left", exp_q.size(), 0);
        if (poke) begin
            repeat (20) @(posedge t_clk);
            #1;
            check("start_ignored_busy", busy, 0);
            check("start_ignored_done", done_cnt - d0, 1);
        end
    endtask

    initial begin : main
        int n;
        vecs[0] = '{16'h2211, 3,  9'h111, 9'h122, 1'b1};
        vecs[1] = '{16'h4433, 3,  9'h133, 9'h144, 1'b1};
        vecs[2] = '{16'h6655, 3,  9'h155, 9'h166, 1'b0};
        vecs[3] = '{16'hA5F0, 0,  9'h1F0, 9'h1A5, 1'b1};
        vecs[4] = '{16'h0081, 50, 9'h181, 9'h100, 1'b1};
        vecs[5] = '{16'h7E3C, 1,  9'h13C, 9'h17E, 1'b0};
        vecs[6] = '{16'hFFFF, 2,  9'h1FF, 9'h1FF, 1'b1};
        vecs[7] = '{16'h1234, 5,  9'h134, 9'h112, 1'b1};
        vecs[8] = '{16'hC3DD, 0,  9'h1DD, 9'h1C3, 1'b0};

        repeat (3) @(posedge t_clk);
        #1;
        check("reset_outputs",
              {spi_mclk, spi_mosi, spi_cs, spi_rs, spi_reset, bufferRtR, frame_done, busy},
              8'b0111_0001);
        power_up();
        for (int f = 0; f < 3; f++) run_frame(f, f == 2);

        // Reset in the middle of a data byte.
        exp_q.push_back(9'h02C);
        frame_start = 1'b1;
        @(posedge t_clk); #1;
        frame_start = 1'b0;
        n = 0;
        while (bufferRtR !== 1'b1 && n < 500) begin @(posedge t_clk); #1; n++; end
        buffer = 16'hBEEF;
        bufferDA = 1'b1;
        @(posedge t_clk); #1;
        bufferDA = 1'b0;
        repeat (5) @(posedge t_clk);
        #1;
        check("mid_byte_cs_low", spi_cs, 0);
        #2 t_rst = 1'b1;
        #1;
        check("abort_outputs",
              {spi_mclk, spi_mosi, spi_cs, spi_rs, spi_reset, bufferRtR, frame_done, busy},
              8'b0111_0001);
        repeat (2) @(posedge t_clk);
        power_up();
        run_frame(0, 1'b0);

        n = 0;
        while (!done3 && n < 1000) begin @(posedge t_clk); #1; n++; end
        check("div3_checked", done3, 1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: run still active at %0t, limit 1000000", $time);
        $fatal(1, "watchdog expired");
    end
endmodule
